// File: rtl/recip_seed_pkg.sv
// Shared helpers for the reciprocal-seed datapath: width helper, table entry
// generator and the seed value emitted for a zero divisor.
package recip_seed_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

    // Midpoint-interval reciprocal: 1/(1 + (i+0.5)/2^lut_aw), clamped so entry 0 fits.
    function automatic int unsigned recip_entry(input int unsigned i,
                                                input int unsigned lut_aw,
                                                input int unsigned seed_w);
        longint unsigned num;
        longint unsigned den;
        longint unsigned q;
        longint unsigned lim;
        num = 64'd1 << (seed_w + lut_aw + 1);
        den = (64'd1 << (lut_aw + 1)) + 64'd2 * 64'(i) + 64'd1;
        q   = num / den;
        lim = (64'd1 << seed_w) - 64'd1;
        return 32'((q > lim) ? lim : q);
    endfunction

    function automatic longint unsigned zero_div_seed(input int unsigned seed_w);
        return (64'd1 << seed_w) - 64'd1;
    endfunction

endpackage

// File: rtl/recip_lzc.sv
// Combinational leading-zero counter with an all-zero flag; count is 0 when
// the input is all zeros.
module recip_lzc
    import recip_seed_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned CntW = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CntW-1:0]  cnt_o,
    output logic             zero_o
);

    // Scan upward so the highest set bit is the last to assign the count.
    always_comb begin
        cnt_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (in_i[i]) begin
                cnt_o = CntW'(WIDTH - 1 - i);
            end
        end
    end

    assign zero_o = ~|in_i;

endmodule

// File: rtl/recip_seed_pipe.sv
// Three-stage reciprocal-seed generator: normalise, table lookup, output
// register, with a valid/ready handshake and per-stage stall propagation.
module recip_seed_pipe
    import recip_seed_pkg::*;
#(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned LUT_AW = 8,
    parameter int unsigned SEED_W = 8,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_div,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEED_W-1:0]        out_seed,
    output logic [$clog2(IN_W)-1:0]  out_shift,
    output logic                     out_dz,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int unsigned ShW     = clog2(IN_W);
    localparam int unsigned LutSize = 2 ** LUT_AW;
    localparam logic [SEED_W-1:0] DzSeed = SEED_W'(zero_div_seed(SEED_W));

    logic [SEED_W-1:0] lut [LutSize];

    for (genvar g = 0; g < LutSize; g++) begin : g_lut
        assign lut[g] = SEED_W'(recip_entry(g, LUT_AW, SEED_W));
    end

    logic rdy1, rdy2, rdy3;
    logic v1_q, v2_q, v3_q;

    logic [ShW-1:0]    lzc_cnt;
    logic              lzc_zero;
    logic [IN_W-1:0]   norm;
    logic              unused_norm;
    logic [LUT_AW-1:0] addr_d, addr1_q;
    logic [ShW-1:0]    shift_d, shift1_q, shift2_q;
    logic              dz1_q, dz2_q;
    logic [TAG_W-1:0]  tag1_q, tag2_q;
    logic [SEED_W-1:0] seed2_d, seed2_q;

    logic [SEED_W-1:0] out_seed_q;
    logic [ShW-1:0]    out_shift_q;
    logic              out_dz_q;
    logic [TAG_W-1:0]  out_tag_q;

    recip_lzc #(
        .WIDTH (IN_W)
    ) u_lzc (
        .in_i   (in_div),
        .cnt_o  (lzc_cnt),
        .zero_o (lzc_zero)
    );

    // A stage may load when it is empty or its content moves on this edge.
    assign rdy3     = ~v3_q | out_ready;
    assign rdy2     = ~v2_q | rdy3;
    assign rdy1     = ~v1_q | rdy2;
    assign in_ready = rdy1;

    always_comb begin
        norm    = in_div << lzc_cnt;
        addr_d  = norm[IN_W-2 -: LUT_AW];
        shift_d = lzc_zero ? '0 : lzc_cnt;
        seed2_d = dz1_q ? DzSeed : lut[addr1_q];
    end

    // Only the address slice is needed; the leading one and low bits are dropped.
    assign unused_norm = ^norm;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_seed_q  <= '0;
            out_shift_q <= '0;
            out_dz_q    <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            if (rdy1) v1_q <= in_valid;
            if (rdy2) v2_q <= v1_q;
            if (rdy3) v3_q <= v2_q;
            if (rdy3 && v2_q) begin
                out_seed_q  <= seed2_q;
                out_shift_q <= shift2_q;
                out_dz_q    <= dz2_q;
                out_tag_q   <= tag2_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy1 && in_valid) begin
            addr1_q  <= addr_d;
            shift1_q <= shift_d;
            dz1_q    <= lzc_zero;
            tag1_q   <= in_tag;
        end
        if (rdy2 && v1_q) begin
            seed2_q  <= seed2_d;
            shift2_q <= shift1_q;
            dz2_q    <= dz1_q;
            tag2_q   <= tag1_q;
        end
    end

    assign out_valid = v3_q;
    assign out_seed  = out_seed_q;
    assign out_shift = out_shift_q;
    assign out_dz    = out_dz_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_recip_seed_pipe.sv
// Directed and scoreboarded bench for recip_seed_pipe at its default parameters.
module tb_recip_seed_pipe;

    typedef struct packed {
        logic [7:0] seed;
        logic [4:0] shift;
        logic       dz;
        logic [3:0] tag;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_div;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_seed;
    logic [4:0]  out_shift;
    logic        out_dz;
    logic [3:0]  out_tag;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_pop = 0;
    logic sb_on = 1'b0;
    exp_t sbq[$];

    logic [7:0] st_seed  [3] = '{8'hFF, 8'hAA, 8'h80};
    logic [4:0] st_shift [3] = '{5'd31, 5'd30, 5'd0};

    recip_seed_pipe #(
        .IN_W   (32),
        .LUT_AW (8),
        .SEED_W (8),
        .TAG_W  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_div    (in_div),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_seed  (out_seed),
        .out_shift (out_shift),
        .out_dz    (out_dz),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_entry(input int a);
        int q;
        q = 131072 / (513 + 2 * a);
        if (q > 255) q = 255;
        return 32'(q);
    endfunction

    function automatic exp_t model(input logic [31:0] d, input logic [3:0] t);
        exp_t        r;
        int          lz;
        logic [31:0] n;
        r.tag = t;
        if (d == 32'd0) begin
            r.seed  = 8'hFF;
            r.shift = 5'd0;
            r.dz    = 1'b1;
        end else begin
            lz = 0;
            while (!d[31-lz]) lz++;
            n       = d << lz;
            r.seed  = 8'(ref_entry(int'(n[30:23])));
            r.shift = 5'(lz);
            r.dz    = 1'b0;
        end
        return r;
    endfunction

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_on && !rst) begin
            if (in_valid && in_ready) sbq.push_back(model(in_div, in_tag));
            if (out_valid && out_ready) begin
                check("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    n_pop++;
                    check("sb_seed", 32'(out_seed), 32'(e.seed));
                    check("sb_shift", 32'(out_shift), 32'(e.shift));
                    check("sb_dz", 32'(out_dz), 32'(e.dz));
                    check("sb_tag", 32'(out_tag), 32'(e.tag));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic        acc;
        int          waited;
        int          nxt;
        logic [31:0] d;

        rst = 1'b1; in_valid = 1'b0; in_div = '0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_seed", 32'(out_seed), 32'd0);
        check("rst_out_shift", 32'(out_shift), 32'd0);
        check("rst_out_dz", 32'(out_dz), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Streaming: 1, 3, 0xFFFFFFFF back to back.
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; in_div = 32'd1; in_tag = 4'h1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin in_div = 32'd3; in_tag = 4'h2; end
            else if (k == 2) begin in_div = 32'hFFFF_FFFF; in_tag = 4'h3; end
            else in_valid = 1'b0;
            @(negedge clk);
            check("st_valid", 32'(out_valid), 32'(k >= 3));
            if (k >= 3) begin
                check("st_seed", 32'(out_seed), 32'(st_seed[k-3]));
                check("st_shift", 32'(out_shift), 32'(st_shift[k-3]));
                check("st_dz", 32'(out_dz), 32'd0);
                check("st_tag", 32'(out_tag), 32'(k - 2));
            end
        end

        // Zero divisor.
        drain();
        in_valid = 1'b1; in_div = 32'd0; in_tag = 4'h5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("dz_valid", 32'(out_valid), 32'd1);
        check("dz_flag", 32'(out_dz), 32'd1);
        check("dz_seed", 32'(out_seed), 32'hFF);
        check("dz_shift", 32'(out_shift), 32'd0);
        check("dz_tag", 32'(out_tag), 32'h5);

        // Backpressure: four operands offered with out_ready low.
        drain();
        out_ready = 1'b0;
        in_valid = 1'b1; in_div = 32'h10; in_tag = 4'h1; nxt = 2;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'(c < 3));
            if (c >= 3) begin
                check("bp_hold_valid", 32'(out_valid), 32'd1);
                check("bp_hold_tag", 32'(out_tag), 32'h1);
                check("bp_hold_seed", 32'(out_seed), 32'hFF);
                check("bp_hold_shift", 32'(out_shift), 32'd27);
            end
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                in_tag = 4'(nxt);
                in_div = 32'(nxt) << 4;
                nxt++;
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_tag", 32'(out_tag), 32'h1);
        for (int t = 2; t <= 4; t++) begin
            @(posedge clk); #1;
            if (t == 2) in_valid = 1'b0;
            @(negedge clk);
            check("bp_drain_valid", 32'(out_valid), 32'd1);
            check("bp_drain_tag", 32'(out_tag), 32'(t));
        end

        // Exhaustive table sweep over the address field.
        drain();
        for (int c = 0; c < 259; c++) begin
            if (c < 256) begin
                in_valid = 1'b1;
                in_div   = 32'h8000_0000 | (32'(c) << 23);
                in_tag   = 4'(c);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c >= 3) check("lut_seed", 32'(out_seed), ref_entry(c - 3));
            @(posedge clk); #1;
        end

        // Reset with three operands in flight.
        drain();
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_div = 32'(c + 7); in_tag = 4'(c + 9);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("rf_full", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rf_valid", 32'(out_valid), 32'd0);
        check("rf_tag", 32'(out_tag), 32'd0);
        check("rf_in_ready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rf_stale", 32'(out_valid), 32'd0);
        end

        // Random divisors with out_ready toggling every cycle.
        @(posedge clk); #1;
        sb_on = 1'b1;
        for (int i = 0; i < 200; i++) begin
            d = $urandom >> $urandom_range(0, 31);
            if (i % 17 == 0) d = 32'd0;
            in_valid = 1'b1; in_div = d; in_tag = 4'(i);
            acc = 1'b0; waited = 0;
            while (!acc && waited < 20) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                out_ready = ~out_ready;
                waited++;
            end
            check("rnd_accept", 32'(acc), 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 sb_on = 1'b0;
        check("sb_drained", 32'(sbq.size()), 32'd0);
        check("sb_count", 32'(n_pop), 32'd200);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
